accu1p: RTL and testbench

Pipelined block accumulator that sits directly downstream of the two-stage split-carry adder and consumes its registered sum stream. It sums a programmable number of consecutive valid samples into a widened result. The accumulator is split into an LSB part and an MSB part with a registered inter-part carry, so the critical path matches the upstream adder. A one-cycle flush folds in the final carry, and back-to-back blocks run with no stall.

---
 rtl/accu1p_pkg.sv | 20 ++
 rtl/accu1p_if.sv | 15 +
 rtl/accu1p_cnt.sv | 48 ++++
 rtl/accu1p.sv | 85 ++++++++
 tb/tb_accu1p.sv | 130 +++++++++++++
 5 files changed

// File: rtl/accu1p_pkg.sv
// Shared constants, width helpers and accumulator word type for the accu1p block accumulator.
package accu1p_pkg;

  localparam int unsigned DefWidth  = 19;
  localparam int unsigned DefWidth1 = 9;
  localparam int unsigned DefCntw   = 4;

  function automatic int unsigned calc_accw(int unsigned width, int unsigned cntw);
    return width + cntw;
  endfunction

  function automatic int unsigned calc_width2(int unsigned accw, int unsigned width1);
    return accw - width1;
  endfunction

  localparam int unsigned DefAccw = calc_accw(DefWidth, DefCntw);

  typedef logic [DefAccw-1:0] acc_t;

endpackage

// File: rtl/accu1p_if.sv
// Sample/result bundle between the upstream adder, the accumulator and its consumer.
interface accu1p_if #(
  parameter int unsigned WIDTH = 19,
  parameter int unsigned CNTW  = 4,
  parameter int unsigned ACCW  = WIDTH + CNTW
);
  logic [WIDTH-1:0] x;
  logic             x_valid;
  logic [CNTW-1:0]  blk_len;
  logic [ACCW-1:0]  acc;
  logic             acc_valid;

  modport master (output x, output x_valid, output blk_len, input acc, input acc_valid);
  modport slave  (input x, input x_valid, input blk_len, output acc, output acc_valid);
endinterface

// File: rtl/accu1p_cnt.sv
// Block counter: tracks samples taken, latches the block length, decodes first/last
// sample and registers the one-cycle flush request.
module accu1p_cnt #(
  parameter int unsigned CNTW = 4
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            x_valid_i,
  input  logic [CNTW-1:0] blk_len_i,
  output logic            first_o,
  output logic            flush_o
);

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CNTW-1:0] len_q, len_d;
  logic            flush_q, flush_d;
  logic            first, last;

  always_comb begin
    first   = x_valid_i && (cnt_q == '0);
    // The first sample decides "last" from the live blk_len, since len_q loads on the same edge.
    last    = x_valid_i && (first ? (blk_len_i == '0) : (cnt_q == len_q));
    cnt_d   = cnt_q;
    len_d   = len_q;
    flush_d = 1'b0;
    if (x_valid_i) begin
      if (first) len_d = blk_len_i;
      cnt_d   = last ? '0 : cnt_q + 1'b1;
      flush_d = last;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q   <= '0;
      len_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      flush_q <= flush_d;
    end
  end

  assign first_o = first;
  assign flush_o = flush_q;

endmodule

// File: rtl/accu1p.sv
// Split-carry pipelined block accumulator (LSB/MSB parts with a registered inter-part carry).
// Optional ACCU1P_TESTPORT_EN adds the lsbs_carry observation port.
module accu1p
  import accu1p_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned WIDTH1 = DefWidth1,
  parameter int unsigned CNTW   = DefCntw
) (
  input  logic     clk,
  input  logic     reset,
  accu1p_if.slave  bus
`ifdef ACCU1P_TESTPORT_EN
  ,
  output logic     lsbs_carry
`endif
);

  localparam int unsigned ACCW   = calc_accw(WIDTH, CNTW);
  localparam int unsigned WIDTH2 = calc_width2(ACCW, WIDTH1);
  localparam int unsigned XHIW   = WIDTH - WIDTH1;

  logic [WIDTH1:0]   lo_q, lo_d;
  logic [WIDTH2-1:0] hi_q, hi_d;
  logic [ACCW-1:0]   acc_q, acc_d;
  logic              acc_valid_q, acc_valid_d;
  logic              first, flush;
  logic [WIDTH1-1:0] x_lo;
  logic [WIDTH2-1:0] x_hi;
  logic [WIDTH2-1:0] carry_ext;

  accu1p_cnt #(
    .CNTW (CNTW)
  ) u_cnt (
    .clk_i     (clk),
    .reset_i   (reset),
    .x_valid_i (bus.x_valid),
    .blk_len_i (bus.blk_len),
    .first_o   (first),
    .flush_o   (flush)
  );

  always_comb begin
    x_lo      = bus.x[WIDTH1-1:0];
    x_hi      = {{(WIDTH2 - XHIW){1'b0}}, bus.x[WIDTH-1:WIDTH1]};
    carry_ext = {{(WIDTH2 - 1){1'b0}}, lo_q[WIDTH1]};
    lo_d      = lo_q;
    hi_d      = hi_q;
    if (bus.x_valid) begin
      if (first) begin
        lo_d = {1'b0, x_lo};
        hi_d = x_hi;
      end else begin
        // The LSB carry is folded into hi one cycle late, keeping each add narrow.
        lo_d = {1'b0, lo_q[WIDTH1-1:0]} + {1'b0, x_lo};
        hi_d = hi_q + x_hi + carry_ext;
      end
    end
    // lo/hi still hold the completed block here even if a new block loads this edge.
    acc_d       = flush ? {hi_q + carry_ext, lo_q[WIDTH1-1:0]} : acc_q;
    acc_valid_d = flush;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lo_q        <= '0;
      hi_q        <= '0;
      acc_q       <= '0;
      acc_valid_q <= 1'b0;
    end else begin
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      acc_q       <= acc_d;
      acc_valid_q <= acc_valid_d;
    end
  end

  assign bus.acc       = acc_q;
  assign bus.acc_valid = acc_valid_q;

`ifdef ACCU1P_TESTPORT_EN
  assign lsbs_carry = lo_q[WIDTH1];
`endif

endmodule

// File: tb/tb_accu1p.sv
// Directed, table-driven bench for accu1p: one row per clock, outputs checked 1 ns after the edge.
module tb_accu1p;
  import accu1p_pkg::*;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  accu1p_if #(.WIDTH(DefWidth), .CNTW(DefCntw)) bus ();

`ifdef ACCU1P_TESTPORT_EN
  logic lsbs_carry;
`endif

  accu1p dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ACCU1P_TESTPORT_EN
    ,
    .lsbs_carry (lsbs_carry)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [18:0] x;
    logic        v;
    logic [3:0]  bl;
    logic        rst;
    logic        ev;
    acc_t        ea;
    string       name;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [18:0] x, logic v, logic [3:0] bl, logic rst,
                              logic ev, acc_t ea, string name);
    vec_t r;
    r.x = x; r.v = v; r.bl = bl; r.rst = rst; r.ev = ev; r.ea = ea; r.name = name;
    return r;
  endfunction

  task automatic step(input logic [18:0] x, input logic v, input logic [3:0] bl,
                      input logic rst, input logic ev, input acc_t ea, input string name);
    @(negedge clk);
    bus.x       = x;
    bus.x_valid = v;
    bus.blk_len = bl;
    reset       = rst;
    @(posedge clk);
    #1;
    total_cnt++;
    if (bus.acc_valid === ev) pass_cnt++;
    else $display("FAIL %s acc_valid: got %b want %b", name, bus.acc_valid, ev);
    total_cnt++;
    if (bus.acc === ea) pass_cnt++;
    else $display("FAIL %s acc: got %0d want %0d", name, bus.acc, ea);
  endtask

  initial begin
    pass_cnt    = 0;
    total_cnt   = 0;
    reset       = 1'b1;
    bus.x       = '0;
    bus.x_valid = 1'b0;
    bus.blk_len = '0;

    // Reset state
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, "rst0"));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, "rst1"));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, "idle"));
    // N=4 of 511: LSB carry on every add
    for (int i = 0; i < 4; i++) tbl.push_back(mk(511, 1, 3, 0, 0, 0, "n4_in"));
    tbl.push_back(mk(0, 0, 3, 0, 1, 2044, "n4_out"));
    tbl.push_back(mk(0, 0, 3, 0, 0, 2044, "n4_hold"));
    // N=2 back-to-back, flush overlaps next first sample
    tbl.push_back(mk(1, 1, 1, 0, 0, 2044, "n2_x1"));
    tbl.push_back(mk(2, 1, 1, 0, 0, 2044, "n2_x2"));
    tbl.push_back(mk(3, 1, 1, 0, 1, 3, "n2_x3"));
    tbl.push_back(mk(4, 1, 1, 0, 0, 3, "n2_x4"));
    tbl.push_back(mk(0, 0, 1, 0, 1, 7, "n2_out"));
    tbl.push_back(mk(0, 0, 1, 0, 0, 7, "n2_hold"));
    // N=1 continuous stream
    tbl.push_back(mk(300, 1, 0, 0, 0, 7, "n1_a"));
    tbl.push_back(mk(301, 1, 0, 0, 1, 300, "n1_b"));
    tbl.push_back(mk(302, 1, 0, 0, 1, 301, "n1_c"));
    tbl.push_back(mk(0, 0, 0, 0, 1, 302, "n1_d"));
    tbl.push_back(mk(0, 0, 0, 0, 0, 302, "n1_hold"));
    // N=4 with gaps 0,2,1; blk_len moved to 7 mid-block; junk x while invalid
    tbl.push_back(mk(10, 1, 3, 0, 0, 302, "gap_s1"));
    tbl.push_back(mk(10, 1, 7, 0, 0, 302, "gap_s2"));
    tbl.push_back(mk(999, 0, 7, 0, 0, 302, "gap_i1"));
    tbl.push_back(mk(999, 0, 7, 0, 0, 302, "gap_i2"));
    tbl.push_back(mk(10, 1, 7, 0, 0, 302, "gap_s3"));
    tbl.push_back(mk(7, 0, 7, 0, 0, 302, "gap_i3"));
    tbl.push_back(mk(10, 1, 7, 0, 0, 302, "gap_s4"));
    tbl.push_back(mk(0, 0, 7, 0, 1, 40, "gap_out"));
    tbl.push_back(mk(0, 0, 7, 0, 0, 40, "gap_hold"));

    foreach (tbl[i]) step(tbl[i].x, tbl[i].v, tbl[i].bl, tbl[i].rst, tbl[i].ev, tbl[i].ea,
                          tbl[i].name);

    // N=16 full-scale: widest possible result
    for (int i = 0; i < 16; i++) step(19'd524287, 1, 15, 0, 0, 40, "n16_in");
    step(0, 0, 15, 0, 1, 23'd8388592, "n16_out");
    step(0, 0, 15, 0, 0, 23'd8388592, "n16_hold");

    // Partial block aborted by reset, then a clean block
    step(5, 1, 3, 0, 0, 23'd8388592, "abort_s1");
    step(5, 1, 3, 0, 0, 23'd8388592, "abort_s2");
    step(5, 1, 3, 1, 0, 0, "abort_rst");
    for (int i = 0; i < 4; i++) step(5, 1, 3, 0, 0, 0, "after_rst_in");
    step(0, 0, 3, 0, 1, 20, "after_rst_out");
    step(0, 0, 3, 0, 0, 20, "after_rst_hold");

    // Reset in the flush cycle cancels the pulse
    step(9, 1, 0, 0, 0, 20, "pend_in");
    step(0, 0, 0, 1, 0, 0, "pend_rst");
    step(0, 0, 0, 0, 0, 0, "pend_none");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
